ahb_lite_master: RTL and testbench

- Synthesizable single-master AHB-Lite initiator: accepts word read/write commands on a valid/ready channel, buffers them in a small FIFO, and drives single NONSEQ transfers onto the bus.
- Drives the HADDR/HTRANS/HWDATA/HWRITE/HSEL/HREADY bundle consumed by the AHB VGA peripheral; samples HREADYOUT/HRDATA back.
- Replaces the bench driver when the peripheral runs in the integrated system or on FPGA.

---
 rtl/ahb_lite_master_pkg.sv | 30 +++
 rtl/ahb_cmd_fifo.sv | 69 ++++++
 rtl/ahb_lite_master.sv | 178 +++++++++++++++++
 tb/tb_ahb_lite_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_master_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_master_pkg
// Shared types and constants for the AHB-Lite master and its command FIFO.
//   HTRANS_IDLE / HTRANS_NONSEQ : the only two transfer types the master uses
//   mst_state_t                 : bus sequencer states IDLE / ADDR / DATA
//   ahb_cmd_t                   : one queued command {write, addr, wdata}
// The command struct is sized by AHB_ADDR_W / AHB_DATA_W; the top-level
// ADDR_W / DATA_W parameters must be left equal to these.
// ---------------------------------------------------------------------------
package ahb_lite_master_pkg;

   localparam int AHB_ADDR_W = 32;
   localparam int AHB_DATA_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } mst_state_t;

   typedef struct packed {
      logic                  write;
      logic [AHB_ADDR_W-1:0] addr;
      logic [AHB_DATA_W-1:0] wdata;
   } ahb_cmd_t;

endpackage

// File: rtl/ahb_cmd_fifo.sv
// ---------------------------------------------------------------------------
// ahb_cmd_fifo
// Synchronous FIFO of ahb_cmd_t commands, CMD_DEPTH entries (power of two,
// at least 2). The head entry is presented combinationally so the sequencer
// can load the address phase on the same edge that pops it.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (flushes FIFO)
//   push_i, push_data_i write request and command
//   pop_i, head_o       pop request and current head command
//   full_o, empty_o     occupancy flags
// A push while full is taken only when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module ahb_cmd_fifo
   import ahb_lite_master_pkg::*;
#(
   parameter int CMD_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push_i,
   input  ahb_cmd_t push_data_i,
   input  logic     pop_i,
   output ahb_cmd_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);

   ahb_cmd_t         mem_q [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             wr_en;
   logic             rd_en;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign rd_en   = pop_i && !empty_o;
   assign wr_en   = push_i && (!full_o || rd_en);
   assign head_o  = mem_q[rd_ptr_q];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers wrap naturally because CMD_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ahb_lite_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_master
// Single-master AHB-Lite initiator. Word read/write commands arrive on a
// valid/ready channel, are queued in ahb_cmd_fifo and issued as single
// NONSEQ transfers. Each completed transfer produces a one-cycle rsp_valid.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata    command channel (addr[1:0] ignored)
//   rsp_valid/write/rdata               completion pulse (rdata 0 on writes)
//   busy                                FIFO non-empty or transfer active
//   HADDR HTRANS HWRITE HSEL HWDATA HREADY   AHB-Lite master outputs
//   HREADYOUT HRDATA                    slave response
// Build option: define AHB_LITE_MASTER_PIPELINE_EN to overlap the next
// address phase with the current data phase (one transfer per cycle).
// Without it every transfer runs ADDR -> DATA -> IDLE.
// ---------------------------------------------------------------------------
module ahb_lite_master
   import ahb_lite_master_pkg::*;
#(
   parameter int ADDR_W    = AHB_ADDR_W,
   parameter int DATA_W    = AHB_DATA_W,
   parameter int CMD_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic              HSEL,
   output logic [DATA_W-1:0] HWDATA,
   output logic              HREADY,
   input  logic              HREADYOUT,
   input  logic [DATA_W-1:0] HRDATA
);

   mst_state_t        state_q, state_d;
   logic              nonseq_q, nonseq_d;      // address phase on the bus
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic              hwrite_q, hwrite_d;
   logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;  // wdata of the address-phase command
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic              dp_write_q, dp_write_d;  // direction of the data-phase command
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   ahb_cmd_t          push_cmd;
   ahb_cmd_t          head_cmd;
   logic              fifo_full, fifo_empty, fifo_pop, load_ap;
   logic              unused_addr_lsbs;

   assign unused_addr_lsbs = ^cmd_addr[1:0];
   assign push_cmd  = '{write: cmd_write, addr: {cmd_addr[ADDR_W-1:2], 2'b00}, wdata: cmd_wdata};
   assign cmd_ready = !fifo_full;

   ahb_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (cmd_valid && cmd_ready),
      .push_data_i (push_cmd),
      .pop_i       (fifo_pop),
      .head_o      (head_cmd),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      nonseq_d    = nonseq_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      ap_wdata_d  = ap_wdata_q;
      hwdata_d    = hwdata_q;
      dp_write_d  = dp_write_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      load_ap     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               load_ap = 1'b1;
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (HREADYOUT) begin
               hwdata_d   = ap_wdata_q;
               dp_write_d = hwrite_q;
               nonseq_d   = 1'b0;
               state_d    = DATA;
`ifdef AHB_LITE_MASTER_PIPELINE_EN
               load_ap    = !fifo_empty;
`endif
            end
         end
         DATA: begin
            if (HREADYOUT) begin
               rsp_valid_d = 1'b1;
               rsp_write_d = dp_write_q;
               rsp_rdata_d = dp_write_q ? '0 : HRDATA;
               state_d     = IDLE;
`ifdef AHB_LITE_MASTER_PIPELINE_EN
               // The overlapped address phase completes on the same edge and
               // becomes the next data phase.
               if (nonseq_q) begin
                  hwdata_d   = ap_wdata_q;
                  dp_write_d = hwrite_q;
                  nonseq_d   = 1'b0;
                  state_d    = DATA;
                  load_ap    = !fifo_empty;
               end else if (!fifo_empty) begin
                  load_ap = 1'b1;
                  state_d = ADDR;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      // Popping the head starts a new address phase.
      if (load_ap) begin
         nonseq_d   = 1'b1;
         haddr_d    = head_cmd.addr;
         hwrite_d   = head_cmd.write;
         ap_wdata_d = head_cmd.wdata;
      end
   end

   assign fifo_pop = load_ap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         nonseq_q    <= 1'b0;
         haddr_q     <= '0;
         hwrite_q    <= 1'b0;
         ap_wdata_q  <= '0;
         hwdata_q    <= '0;
         dp_write_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         nonseq_q    <= nonseq_d;
         haddr_q     <= haddr_d;
         hwrite_q    <= hwrite_d;
         ap_wdata_q  <= ap_wdata_d;
         hwdata_q    <= hwdata_d;
         dp_write_q  <= dp_write_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign HADDR     = haddr_q;
   assign HTRANS    = nonseq_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HSEL      = nonseq_q;
   assign HWRITE    = hwrite_q;
   assign HWDATA    = hwdata_q;
   assign HREADY    = HREADYOUT;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

   localparam int DEPTH = 4;
`ifdef AHB_LITE_MASTER_PIPELINE_EN
   localparam int NS_GAP = 1;
`else
   localparam int NS_GAP = 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_write, busy;
   logic [31:0] rsp_rdata;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HSEL, HREADY;
   logic        HREADYOUT = 1'b1;
   logic [31:0] HRDATA = '0;

   ahb_lite_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .busy(busy),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSEL(HSEL), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } cmd_t;
   cmd_t        issue_q[$];
   cmd_t        head_c;
   int          acc_cnt = 0, pop_cnt = 0, outstanding = 0;
   bit          ap_open = 0, dp_pending = 0, dp_write = 0;
   logic [31:0] dp_wdata = '0;
   int          dp_age = 0, dp_waits = 0;
   bit          rsp_exp = 0, rsp_exp_w = 0;
   logic [31:0] rsp_exp_d = '0;
   int          cyc = 0, last_acc_cyc = 0, first_ns_cyc = 0, last_rsp_cyc = 0, n_rsp = 0;
   logic [31:0] last_haddr = '0, last_rsp_rdata = '0;
   int          ns_acc_cyc[$];
   bit          saw_full = 0;
   int          wait_fixed = 0;
   bit          wait_rand = 0, rdata_fix_en = 0;
   logic [31:0] rdata_fix = '0;

   // Slave: wait states only while a data phase is open, random read data.
   initial forever begin
      @(posedge clk); #1;
      HREADYOUT = !(dp_pending && (dp_age < dp_waits));
      HRDATA    = rdata_fix_en ? rdata_fix : $urandom;
   end

   // Monitor: values seen here are what the next posedge will sample.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         issue_q.delete();
         acc_cnt = 0; pop_cnt = 0; outstanding = 0;
         ap_open = 0; dp_pending = 0; dp_age = 0; rsp_exp = 0;
      end else begin
         if (HTRANS == 2'b10 && !ap_open) begin
            pop_cnt++; ap_open = 1; first_ns_cyc = cyc;
         end
         check_eq("rsp_valid", rsp_valid, rsp_exp);
         if (rsp_valid) begin
            n_rsp++; last_rsp_cyc = cyc; last_rsp_rdata = rsp_rdata;
         end
         if (rsp_exp) begin
            check_eq("rsp_write", rsp_write, rsp_exp_w);
            check_eq("rsp_rdata", rsp_rdata, rsp_exp_d);
            $display("rsp  t=%0t write=%0d rdata=0x%08h", $time, rsp_write, rsp_rdata);
         end
         check_eq("busy", busy, outstanding > 0);
         check_eq("cmd_ready", cmd_ready, (acc_cnt - pop_cnt) < DEPTH);
         if (!cmd_ready) saw_full = 1;
         check_eq("hsel", HSEL, HTRANS == 2'b10);
         check_eq("htrans_legal", (HTRANS == 2'b00) || (HTRANS == 2'b10), 1'b1);
         check_eq("hready", HREADY, HREADYOUT);
         // events at the coming posedge
         rsp_exp = 0;
         if (dp_pending) begin
            if (HREADYOUT) begin
               if (dp_write) check_eq("hwdata", HWDATA, dp_wdata);
               rsp_exp = 1; rsp_exp_w = dp_write;
               rsp_exp_d = dp_write ? 32'h0 : HRDATA;
               outstanding--; dp_pending = 0;
            end else begin
               dp_age++;
            end
         end
         if (HTRANS == 2'b10 && HREADYOUT) begin
            check_eq("nonseq_has_cmd", issue_q.size() > 0, 1'b1);
            if (issue_q.size() > 0) begin
               head_c = issue_q.pop_front();
               check_eq("haddr", HADDR, {head_c.a[31:2], 2'b00});
               check_eq("hwrite", HWRITE, head_c.w);
               dp_pending = 1; dp_write = head_c.w; dp_wdata = head_c.d; dp_age = 0;
               dp_waits = wait_rand ? int'($urandom_range(0, 3)) : wait_fixed;
            end
            last_haddr = HADDR;
            ns_acc_cyc.push_back(cyc);
            ap_open = 0;
         end
         if (cmd_valid && cmd_ready) begin
            issue_q.push_back({cmd_write, cmd_addr, cmd_wdata});
            acc_cnt++; outstanding++; last_acc_cyc = cyc;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
      bit took = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      for (int i = 0; i < 500 && !took; i++) begin
         @(negedge clk); took = cmd_ready;
         @(posedge clk); #1;
      end
      check_eq("push_accepted", took, 1'b1);
      $display("cmd  t=%0t write=%0d addr=0x%08h wdata=0x%08h", $time, w, a, d);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((outstanding != 0 || rsp_exp) && n < 3000) begin
         tick(); n++;
      end
      check_eq("drain_in_time", n < 3000, 1'b1);
      tick(); tick();
   endtask

   int rsp0;

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_htrans", HTRANS, 2'b00);
      check_eq("rst_hsel", HSEL, 1'b0);
      check_eq("rst_hwrite", HWRITE, 1'b0);
      check_eq("rst_haddr", HADDR, 32'h0);
      check_eq("rst_hwdata", HWDATA, 32'h0);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_write", rsp_write, 1'b0);
      check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
      check_eq("rst_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check_eq("rst_cmd_ready", cmd_ready, 1'b1);

      // single zero-wait write
      rsp0 = n_rsp;
      push_cmd(1'b1, 32'h5000_0004, 32'h0000_0041);
      wait_idle();
      check_eq("wr_nonseq_latency", first_ns_cyc - last_acc_cyc, 2);
      check_eq("wr_rsp_latency", last_rsp_cyc - last_acc_cyc, 4);
      check_eq("wr_haddr", last_haddr, 32'h5000_0004);
      check_eq("wr_rsp_count", n_rsp - rsp0, 1);

      // single read with 3 wait states
      wait_fixed = 3; rdata_fix_en = 1; rdata_fix = 32'hDEAD_BEEF;
      rsp0 = n_rsp;
      push_cmd(1'b0, 32'h5000_0000, 32'h0);
      wait_idle();
      check_eq("rd_rsp_count", n_rsp - rsp0, 1);
      check_eq("rd_rsp_rdata", last_rsp_rdata, 32'hDEAD_BEEF);
      check_eq("rd_rsp_latency", last_rsp_cyc - last_acc_cyc, 7);
      rdata_fix_en = 0; wait_fixed = 0;

      // unaligned address
      push_cmd(1'b1, 32'h5000_0007, 32'h0000_0077);
      wait_idle();
      check_eq("unaligned_haddr", last_haddr, 32'h5000_0004);

      // overfill the FIFO under slow data phases
      wait_fixed = 6; saw_full = 0; rsp0 = n_rsp;
      for (int i = 0; i < 6; i++) push_cmd(i[0], 32'h5000_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i));
      wait_idle();
      check_eq("fifo_saw_full", saw_full, 1'b1);
      check_eq("burst6_rsp_count", n_rsp - rsp0, 6);
      check_eq("burst6_busy_end", busy, 1'b0);
      wait_fixed = 0;

      // NONSEQ spacing for back-to-back zero-wait writes
      ns_acc_cyc.delete(); rsp0 = n_rsp;
      for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'h5000_0200 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      wait_idle();
      check_eq("spacing_count", ns_acc_cyc.size(), 4);
      if (ns_acc_cyc.size() == 4)
         for (int i = 1; i < 4; i++) check_eq("nonseq_spacing", ns_acc_cyc[i] - ns_acc_cyc[i-1], NS_GAP);
      check_eq("spacing_rsp_count", n_rsp - rsp0, 4);

      // randomized traffic
      wait_rand = 1;
      for (int i = 0; i < 150; i++) begin
         push_cmd(1'($urandom), 32'h5000_0000 | ($urandom & 32'h0000_FFFF), $urandom);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
      end
      wait_idle();
      wait_rand = 0;

      // reset during a waited write data phase with a command still queued
      wait_fixed = 50; rsp0 = n_rsp;
      push_cmd(1'b1, 32'h5000_0010, 32'h0000_1234);
      push_cmd(1'b0, 32'h5000_0014, 32'h0);
      for (int n = 0; n < 100 && !dp_pending; n++) tick();
      check_eq("rstmid_in_data", dp_pending, 1'b1);
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check_eq("rstmid_htrans", HTRANS, 2'b00);
      check_eq("rstmid_hsel", HSEL, 1'b0);
      check_eq("rstmid_hwdata", HWDATA, 32'h0);
      check_eq("rstmid_busy", busy, 1'b0);
      check_eq("rstmid_rsp_valid", rsp_valid, 1'b0);
      tick(); tick();
      rst_n = 1'b1;
      wait_fixed = 0;
      tick();
      check_eq("rstmid_cmd_ready", cmd_ready, 1'b1);
      repeat (10) tick();
      check_eq("rstmid_no_rsp", n_rsp - rsp0, 0);
      check_eq("rstmid_busy_after", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
